// File: rtl/keccak_pkg.sv
// Shared Keccak message-path constants and the packer state encoding.
package keccak_pkg;

  localparam int unsigned RATE_BITS       = 576;
  localparam int unsigned WORD_BITS       = 64;
  localparam int unsigned WORDS_PER_BLOCK = RATE_BITS / WORD_BITS;
  localparam int unsigned RATE_BYTES      = RATE_BITS / 8;
  localparam int unsigned DIN_BYTES_W     = 4;
  localparam int unsigned BYTE_NUM_W      = 10;

  typedef enum logic [1:0] {
    ST_FILL       = 2'd0,
    ST_SEND       = 2'd1,
    ST_SEND_EMPTY = 2'd2
  } state_t;

endpackage

// File: rtl/msg_packer_576_if.sv
// Word-stream input and block output of the message packer, with padder back-pressure.
interface msg_packer_576_if #(
  parameter int unsigned RATE_BITS = keccak_pkg::RATE_BITS,
  parameter int unsigned WORD_BITS = keccak_pkg::WORD_BITS
);

  logic [WORD_BITS-1:0]               din;
  logic                               din_valid;
  logic                               din_last;
  logic [keccak_pkg::DIN_BYTES_W-1:0] din_bytes;
  logic                               din_ready;

  logic [RATE_BITS-1:0]               out;
  logic                               out_ready;
  logic                               out_last;
  logic [keccak_pkg::BYTE_NUM_W-1:0]  out_byte_num;
  logic                               buffer_full;

  // Environment side: message source and padder.
  modport master (
    output din, din_valid, din_last, din_bytes, buffer_full,
    input  din_ready, out, out_ready, out_last, out_byte_num
  );

  // Packer side.
  modport slave (
    input  din, din_valid, din_last, din_bytes, buffer_full,
    output din_ready, out, out_ready, out_last, out_byte_num
  );

endinterface

// File: rtl/msg_packer_576.sv
// Packs 64-bit message words into 576-bit rate blocks for the Keccak padder,
// masking the final word and emitting a trailing empty block when the message fills a block exactly.
module msg_packer_576 #(
  parameter int unsigned RATE_BITS = keccak_pkg::RATE_BITS,
  parameter int unsigned WORD_BITS = keccak_pkg::WORD_BITS
) (
  input  logic             clk,
  input  logic             reset,
  msg_packer_576_if.slave  bus
);

  localparam int unsigned WORDS      = RATE_BITS / WORD_BITS;
  localparam int unsigned WORD_BYTES = WORD_BITS / 8;
  localparam int unsigned RBYTES     = RATE_BITS / 8;
  localparam int unsigned WCNT_W     = $clog2(WORDS);
  localparam int unsigned BCNT_W     = $clog2(RBYTES + 1);
  localparam int unsigned DB_W       = keccak_pkg::DIN_BYTES_W;
  localparam int unsigned BN_W       = keccak_pkg::BYTE_NUM_W;

  keccak_pkg::state_t    state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [RATE_BITS-1:0]  buf_q, buf_d;
  logic                  pend_empty_q, pend_empty_d;
  logic                  out_ready_q, out_ready_d;
  logic                  out_last_q, out_last_d;
  logic [BN_W-1:0]       out_bn_q, out_bn_d;

  logic                  accept;
  logic [DB_W-1:0]       nbytes;
  logic [WORD_BITS-1:0]  word;
  logic [BCNT_W-1:0]     bcnt_sum;

  // Zero every byte at or beyond nbytes; byte 0 sits in the top lane.
  function automatic logic [WORD_BITS-1:0] mask_tail(input logic [WORD_BITS-1:0] w,
                                                     input logic [DB_W-1:0]      n);
    logic [WORD_BITS-1:0] m;
    m = w;
    for (int unsigned b = 0; b < WORD_BYTES; b++) begin
      if (DB_W'(b) >= n) m[WORD_BITS-1-8*b -: 8] = '0;
    end
    return m;
  endfunction

  assign bus.din_ready    = (state_q == keccak_pkg::ST_FILL) && !reset;
  assign bus.out          = buf_q;
  assign bus.out_ready    = out_ready_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_byte_num = out_bn_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= keccak_pkg::ST_FILL;
      wcnt_q       <= '0;
      bcnt_q       <= '0;
      buf_q        <= '0;
      pend_empty_q <= 1'b0;
      out_ready_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_bn_q     <= '0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      bcnt_q       <= bcnt_d;
      buf_q        <= buf_d;
      pend_empty_q <= pend_empty_d;
      out_ready_q  <= out_ready_d;
      out_last_q   <= out_last_d;
      out_bn_q     <= out_bn_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    bcnt_d       = bcnt_q;
    buf_d        = buf_q;
    pend_empty_d = pend_empty_q;
    out_ready_d  = out_ready_q;
    out_last_d   = out_last_q;
    out_bn_d     = out_bn_q;

    accept   = bus.din_valid && (state_q == keccak_pkg::ST_FILL);
    nbytes   = DB_W'(WORD_BYTES);
    if (bus.din_last && (bus.din_bytes < DB_W'(WORD_BYTES))) nbytes = bus.din_bytes;
    word     = bus.din_last ? mask_tail(bus.din, nbytes) : bus.din;
    bcnt_sum = bcnt_q + BCNT_W'(nbytes);

    case (state_q)
      keccak_pkg::ST_FILL: begin
        if (accept) begin
          for (int unsigned i = 0; i < WORDS; i++) begin
            if (wcnt_q == WCNT_W'(i)) buf_d[(WORDS-1-i)*WORD_BITS +: WORD_BITS] = word;
          end
          bcnt_d = bcnt_sum;
          if (bus.din_last || (wcnt_q == WCNT_W'(WORDS - 1))) begin
            state_d      = keccak_pkg::ST_SEND;
            out_ready_d  = 1'b1;
            out_bn_d     = BN_W'(bcnt_sum);
            // A final word that exactly fills the block still needs a zero-byte closing block.
            out_last_d   = bus.din_last && (bcnt_sum != BCNT_W'(RBYTES));
            pend_empty_d = bus.din_last && (bcnt_sum == BCNT_W'(RBYTES));
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end

      keccak_pkg::ST_SEND: begin
        if (!bus.buffer_full) begin
          buf_d        = '0;
          wcnt_d       = '0;
          bcnt_d       = '0;
          out_bn_d     = '0;
          pend_empty_d = 1'b0;
          if (pend_empty_q) begin
            state_d     = keccak_pkg::ST_SEND_EMPTY;
            out_ready_d = 1'b1;
            out_last_d  = 1'b1;
          end else begin
            state_d     = keccak_pkg::ST_FILL;
            out_ready_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end

      keccak_pkg::ST_SEND_EMPTY: begin
        if (!bus.buffer_full) begin
          state_d     = keccak_pkg::ST_FILL;
          out_ready_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end

      default: state_d = keccak_pkg::ST_FILL;
    endcase
  end

endmodule

// File: tb/tb_msg_packer_576.sv
// Self-checking bench for msg_packer_576: vector table, random messages against a byte-level model,
// and directed latency / back-pressure / reset sequences.
module tb_msg_packer_576;
  import keccak_pkg::*;

  typedef logic [RATE_BITS-1:0] blk_t;
  typedef struct {
    blk_t data;
    int   bn;
    bit   last;
  } exp_blk_t;
  typedef struct {
    int nwords;
    int lb;
    bit fixed;
    int exp_blocks;
    int exp_final_bn;
  } vec_t;

  localparam int MAX_CYC = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  msg_packer_576_if bus ();
  msg_packer_576 dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int n_vec = 0;
  int n_err = 0;
  exp_blk_t exp_q[$];
  vec_t vt[8];

  task automatic chk(input string name, input blk_t act, input blk_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: flatten the message to bytes, then cut into 72-byte blocks; the block
  // after the last full one (possibly empty) is the final one.
  function automatic void model(input logic [63:0] words[$], input int lb);
    logic [7:0] bq[$];
    logic [63:0] w;
    int n, pos;
    exp_blk_t e;
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      n = (i == words.size() - 1) ? ((lb > 8) ? 8 : lb) : 8;
      for (int k = 0; k < n; k++) bq.push_back(w[63-8*k -: 8]);
    end
    exp_q.delete();
    pos = 0;
    forever begin
      n = bq.size() - pos;
      if (n > RATE_BYTES) n = RATE_BYTES;
      e.data = '0;
      for (int k = 0; k < n; k++) e.data[RATE_BITS-1-8*k -: 8] = bq[pos+k];
      e.bn   = n;
      e.last = (n < RATE_BYTES);
      exp_q.push_back(e);
      pos += n;
      if (e.last) break;
    end
  endfunction

  task automatic idle_inputs();
    bus.din_valid   = 1'b0;
    bus.din         = '0;
    bus.din_last    = 1'b0;
    bus.din_bytes   = '0;
    bus.buffer_full = 1'b0;
  endtask

  task automatic run_msg(input int nwords, input int lb, input bit fixed, input bit stress,
                         output int nblocks, output int final_bn);
    logic [63:0] words[$];
    int wi, bi, cyc;
    for (int i = 0; i < nwords; i++) words.push_back(fixed ? 64'h90AB_CDEF_1111_1111 : {$urandom, $urandom});
    model(words, lb);
    wi = 0; bi = 0; cyc = 0; nblocks = 0; final_bn = -1;
    while ((wi < nwords || bi < exp_q.size()) && cyc < MAX_CYC) begin
      @(negedge clk);
      cyc++;
      if (wi < nwords && (!stress || $urandom_range(3) != 0)) begin
        bus.din_valid = 1'b1;
        bus.din       = words[wi];
        bus.din_last  = (wi == nwords - 1);
        bus.din_bytes = (wi == nwords - 1) ? 4'(lb) : 4'($urandom_range(15));
      end else begin
        bus.din_valid = 1'b0;
        bus.din       = {$urandom, $urandom};
        bus.din_last  = 1'($urandom_range(1));
        bus.din_bytes = 4'($urandom_range(15));
      end
      bus.buffer_full = stress ? ($urandom_range(2) == 0) : 1'b0;
      #1;
      if (bus.out_ready) chk("din_ready_in_send", blk_t'(bus.din_ready), '0);
      if (bus.out_ready && !bus.buffer_full) begin
        if (bi < exp_q.size()) begin
          chk("blk_data", bus.out, exp_q[bi].data);
          chk("blk_byte_num", blk_t'(bus.out_byte_num), blk_t'(exp_q[bi].bn));
          chk("blk_last", blk_t'(bus.out_last), blk_t'(exp_q[bi].last));
        end else begin
          n_vec++; n_err++;
          $display("FAIL extra_block: got byte_num %0d expected no block", bus.out_byte_num);
        end
        nblocks++;
        final_bn = int'(bus.out_byte_num);
        bi++;
      end
      if (bus.din_valid && bus.din_ready) wi++;
    end
    idle_inputs();
    if (cyc >= MAX_CYC) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got %0d words %0d blocks expected %0d words %0d blocks", wi, bi, nwords, exp_q.size());
    end
  endtask

  initial begin
    int nb, fb;
    blk_t e, hold_out;
    logic [BYTE_NUM_W-1:0] hold_bn;
    logic hold_last;

    vt[0] = '{nwords: 9,  lb: 8,  fixed: 1'b1, exp_blocks: 2, exp_final_bn: 0};
    vt[1] = '{nwords: 1,  lb: 1,  fixed: 1'b1, exp_blocks: 1, exp_final_bn: 1};
    vt[2] = '{nwords: 12, lb: 4,  fixed: 1'b0, exp_blocks: 2, exp_final_bn: 20};
    vt[3] = '{nwords: 1,  lb: 0,  fixed: 1'b0, exp_blocks: 1, exp_final_bn: 0};
    vt[4] = '{nwords: 9,  lb: 0,  fixed: 1'b0, exp_blocks: 1, exp_final_bn: 64};
    vt[5] = '{nwords: 10, lb: 0,  fixed: 1'b0, exp_blocks: 2, exp_final_bn: 0};
    vt[6] = '{nwords: 3,  lb: 15, fixed: 1'b0, exp_blocks: 1, exp_final_bn: 24};
    vt[7] = '{nwords: 18, lb: 8,  fixed: 1'b0, exp_blocks: 3, exp_final_bn: 0};

    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_ready", blk_t'(bus.out_ready), '0);
    chk("rst_out_last", blk_t'(bus.out_last), '0);
    chk("rst_byte_num", blk_t'(bus.out_byte_num), '0);
    chk("rst_out", bus.out, '0);
    chk("rst_din_ready", blk_t'(bus.din_ready), '0);
    reset = 1'b0;
    #1 chk("rel_din_ready", blk_t'(bus.din_ready), blk_t'(1));

    // Single byte message: one-cycle latency, masked tail.
    @(negedge clk);
    bus.din = 64'h90AB_CDEF_1111_1111; bus.din_last = 1'b1; bus.din_bytes = 4'd1;
    bus.din_valid = 1'b1; bus.buffer_full = 1'b1;
    #1 chk("lat_pre_ready", blk_t'(bus.out_ready), '0);
    @(negedge clk);
    bus.din_valid = 1'b0;
    e = '0; e[RATE_BITS-1 -: 8] = 8'h90;
    chk("lat_ready", blk_t'(bus.out_ready), blk_t'(1));
    chk("lat_out", bus.out, e);
    chk("lat_byte_num", blk_t'(bus.out_byte_num), blk_t'(1));
    chk("lat_last", blk_t'(bus.out_last), blk_t'(1));
    bus.buffer_full = 1'b0;
    @(negedge clk);
    chk("lat_done", blk_t'(bus.out_ready), '0);

    // Back-pressure: block must hold and input must stall for 5 cycles.
    bus.din = 64'h1111_2222_3333_4444; bus.din_last = 1'b0; bus.din_bytes = 4'd3;
    bus.din_valid = 1'b1; bus.buffer_full = 1'b1;
    @(negedge clk);
    bus.din = 64'h5555_6666_7777_8888; bus.din_last = 1'b1; bus.din_bytes = 4'd8;
    @(negedge clk);
    bus.din = 64'hDEAD_BEEF_DEAD_BEEF; bus.din_bytes = 4'd2;
    e = '0; e[RATE_BITS-1 -: 128] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    hold_out = bus.out; hold_bn = bus.out_byte_num; hold_last = bus.out_last;
    chk("bp_out", hold_out, e);
    chk("bp_byte_num", blk_t'(hold_bn), blk_t'(16));
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("bp_hold_out", bus.out, hold_out);
      chk("bp_hold_bn", blk_t'(bus.out_byte_num), blk_t'(hold_bn));
      chk("bp_hold_last", blk_t'(bus.out_last), blk_t'(hold_last));
      chk("bp_din_ready", blk_t'(bus.din_ready), '0);
    end
    bus.buffer_full = 1'b0; bus.din_valid = 1'b0;
    @(negedge clk);
    chk("bp_release", blk_t'(bus.out_ready), '0);
    chk("bp_cleared", bus.out, '0);

    // Reset after 4 accepted words discards the partial block.
    for (int i = 0; i < 4; i++) begin
      bus.din = {$urandom, $urandom}; bus.din_last = 1'b0; bus.din_valid = 1'b1;
      @(negedge clk);
    end
    bus.din_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", blk_t'(bus.out_ready), '0);
    chk("mid_rst_out", bus.out, '0);
    chk("mid_rst_din_ready", blk_t'(bus.din_ready), '0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("mid_rel_din_ready", blk_t'(bus.din_ready), blk_t'(1));
    @(negedge clk);
    bus.din = 64'hA1B2_C3D4_E5F6_0718; bus.din_last = 1'b1; bus.din_bytes = 4'd3; bus.din_valid = 1'b1;
    @(negedge clk);
    bus.din_valid = 1'b0;
    e = '0; e[RATE_BITS-1 -: 24] = 24'hA1B2C3;
    chk("post_rst_out", bus.out, e);
    chk("post_rst_byte_num", blk_t'(bus.out_byte_num), blk_t'(3));
    chk("post_rst_last", blk_t'(bus.out_last), blk_t'(1));
    @(negedge clk);

    // Vector table: stress alternates between clean and gapped/back-pressured runs.
    for (int i = 0; i < 8; i++) begin
      run_msg(vt[i].nwords, vt[i].lb, vt[i].fixed, i[0], nb, fb);
      chk($sformatf("vec%0d_blocks", i), blk_t'(nb), blk_t'(vt[i].exp_blocks));
      chk($sformatf("vec%0d_final_bn", i), blk_t'(fb), blk_t'(vt[i].exp_final_bn));
    end

    // Random messages against the model.
    for (int i = 0; i < 25; i++) begin
      run_msg($urandom_range(1, 20), $urandom_range(0, 15), 1'b0, 1'b1, nb, fb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msg_packer_576.md
MSG_PACKER_576 -- requirements
Module: msg_packer_576

Interface
REQ-001 Parameter RATE_BITS, default 576, sponge rate in bits delivered per block.
REQ-002 Parameter WORD_BITS, default 64, input word width; RATE_BITS/WORD_BITS = 9 words per block.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  64  message word; byte 0 = din[63:56].
REQ-006 din_valid  input  1  din/din_last/din_bytes valid this cycle.
REQ-007 din_last  input  1  din is final word of message.
REQ-008 din_bytes  input  4  valid bytes in final word, 0..8; ignored when din_last=0.
REQ-009 din_ready  output  1  packer accepts a word this cycle.
REQ-010 out  output  576  block to padder; word 0 in out[575:512], word 8 in out[63:0].
REQ-011 out_ready  output  1  block valid; drives padder in_ready.
REQ-012 out_last  output  1  final block of message; drives padder is_last.
REQ-013 out_byte_num  output  10  valid message bytes in out, 0..72; drives padder byte_num.
REQ-014 buffer_full  input  1  padder back-pressure; block not accepted while high.

Function
REQ-015 Word accepted on rising edge when din_valid=1 and din_ready=1; din_ready=1 only in state FILL.
REQ-016 States: FILL (collecting words), SEND (block presented), SEND_EMPTY (presenting zero-byte final block).
REQ-017 FILL: accepted word written at word index wcnt (0..8), wcnt increments; byte count incremented by 8, or by din_bytes (values >8 clamped to 8) when din_last=1.
REQ-018 Final word: bytes beyond din_bytes zeroed in out; all words after final word zeroed.
REQ-019 FILL->SEND on acceptance of 9th word or of any word with din_last=1; out_ready=1 from the next cycle (1-cycle latency).
REQ-020 SEND: out, out_last, out_byte_num stable while out_ready=1; block accepted on edge where out_ready=1 and buffer_full=0.
REQ-021 out_last=1 iff block contains the final word and out_byte_num<72.
REQ-022 Final word completing exactly 72 bytes: block sent with out_last=0, out_byte_num=72, then SEND->SEND_EMPTY.
REQ-023 SEND_EMPTY: out=0, out_byte_num=0, out_last=1, out_ready=1 until accepted; then ->FILL.
REQ-024 SEND accepted, not final: ->FILL, wcnt=0, byte count=0, buffer cleared to zero.
REQ-025 Empty message (first word din_last=1, din_bytes=0): single block out_byte_num=0, out_last=1.
REQ-026 No input accepted during SEND/SEND_EMPTY; din words held upstream (din_ready=0).
REQ-027 Non-final words always count 8 bytes regardless of din_bytes.

Reset
REQ-028 reset=1 asynchronously forces state FILL, wcnt=0, byte count=0, buffer=0, out_ready=0, out_last=0, out_byte_num=0, din_ready=0 while asserted.
REQ-029 Reset mid-message or mid-SEND discards partial block; din_ready=1 first cycle after reset release.

Structure
REQ-030 Shared package keccak_pkg holds RATE_BITS=576, WORD_BITS=64, WORDS_PER_BLOCK=9, RATE_BYTES=72 and state encoding.
REQ-031 Single module; no sub-module; byte masking of final word a local function.

Verification
REQ-032 9 words 0x90ABCDEF11111111, last on 9th, din_bytes=8 -> block out=9 copies, byte_num=72, out_last=0; then empty block byte_num=0, out_last=1.
REQ-033 1 word din=0x90ABCDEF11111111, last, din_bytes=1 -> out[575:568]=0x90, rest 0, byte_num=1, out_last=1, out_ready 1 cycle after accept.
REQ-034 12 words, last din_bytes=4 -> block1 byte_num=72 last=0; block2 words 0..2, word 2 lower 4 bytes zero, byte_num=20, last=1.
REQ-035 buffer_full=1 for 5 cycles during SEND -> out/out_last/out_byte_num stable, din_ready=0; accepted cycle buffer_full drops.
REQ-036 reset pulsed after 4 words accepted -> out_ready=0, buffer 0; next 1-word message yields byte_num=din_bytes, no stale data.
